// File: rtl/wrapper_data_req_pkg.sv
// Shared types and helpers for the multi-channel AHB data-request wrapper.
package wrapper_data_req_pkg;

  localparam int REGDWIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACTIVE    = 2'd1,
    ST_LAST_DATA = 2'd2
  } state_e;

  // Channel-select field width; a single channel still consumes one address bit.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/wrapper_data_req_ch.sv
// One constructor channel: request FSM plus word counter.
// Optional word-order check enabled by WRAPPER_DATA_REQ_SEQ_CHECK_EN.
module wrapper_data_req_ch
  import wrapper_data_req_pkg::*;
#(
  parameter int CNTW = 4
) (
  input  logic            hclk,
  input  logic            hresetn,
  input  logic            ready_i,
  input  logic            last_hit_i,
  input  logic            wr_i,
  input  logic [CNTW-1:0] word_idx_i,
  input  logic            hreadys_i,
  output logic            data_req_o,
  output logic            packet_done_o,
  output logic            seq_err_o
);

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    data_req_o    = 1'b0;
    packet_done_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        data_req_o = ready_i;
        if (ready_i) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        data_req_o = ready_i & ~last_hit_i;
        if (wr_i) cnt_d = cnt_q + 1'b1;
        if (last_hit_i)    state_d = ST_LAST_DATA;
        else if (!ready_i) state_d = ST_IDLE;
      end
      ST_LAST_DATA: begin
        if (hreadys_i) begin
          packet_done_o = 1'b1;
          state_d       = ST_IDLE;
          cnt_d         = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // In reset the request behaves as from IDLE and a pending packet is abandoned.
    if (!hresetn) begin
      data_req_o    = ready_i;
      packet_done_o = 1'b0;
    end
  end

  // NOTE: reset is synchronous here, and state registers use non-blocking assignments only.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef WRAPPER_DATA_REQ_SEQ_CHECK_EN
  logic seq_err_q;

  always_ff @(posedge hclk) begin
    if (!hresetn) seq_err_q <= 1'b0;
    else          seq_err_q <= (state_q == ST_ACTIVE) && wr_i && (word_idx_i != cnt_q);
  end

  assign seq_err_o = seq_err_q;
`else
  logic unused_word_idx;
  assign unused_word_idx = ^word_idx_i;
  assign seq_err_o       = 1'b0;
`endif

endmodule

// File: rtl/wrapper_data_req_mc.sv
// AHB write decode fanning out to NUM_CH independent data-request channels.
// Word-order checking is built only with WRAPPER_DATA_REQ_SEQ_CHECK_EN.
module wrapper_data_req_mc
  import wrapper_data_req_pkg::*;
#(
  parameter int ADDRWIDTH   = 11,
  parameter int PACKETWIDTH = 512,
  parameter int NUM_CH      = 2
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic                 hsels,
  input  logic [ADDRWIDTH-1:0] haddrs,
  input  logic [1:0]           htranss,
  input  logic                 hwrites,
  input  logic                 hreadys,
  input  logic [NUM_CH-1:0]    constructor_ready,
  output logic [NUM_CH-1:0]    data_req,
  output logic [NUM_CH-1:0]    packet_done,
  output logic [NUM_CH-1:0]    seq_err
);

  localparam int PBW  = $clog2(PACKETWIDTH / 8);
  localparam int CHW  = ch_width(NUM_CH);
  localparam int CNTW = PBW - 2;

  logic            trans_req;
  logic [CHW-1:0]  ch_idx;
  logic [CNTW-1:0] word_idx;
  logic            unused_bits;

  assign trans_req   = hreadys & hsels & htranss[1] & hwrites;
  assign ch_idx      = haddrs[PBW+CHW-1:PBW];
  assign word_idx    = haddrs[PBW-1:2];
  assign unused_bits = ^{haddrs, htranss[0]};

  // Channel indices >= NUM_CH match no instance and are dropped.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic wr_c;
    logic last_hit_c;

    assign wr_c       = trans_req && (ch_idx == CHW'(c));
    assign last_hit_c = wr_c && (&word_idx);

    wrapper_data_req_ch #(.CNTW(CNTW)) u_ch (
      .hclk          (hclk),
      .hresetn       (hresetn),
      .ready_i       (constructor_ready[c]),
      .last_hit_i    (last_hit_c),
      .wr_i          (wr_c),
      .word_idx_i    (word_idx),
      .hreadys_i     (hreadys),
      .data_req_o    (data_req[c]),
      .packet_done_o (packet_done[c]),
      .seq_err_o     (seq_err[c])
    );
  end

endmodule

// File: tb/tb_wrapper_data_req_mc.sv
// Scoreboard bench for wrapper_data_req_mc (PACKETWIDTH=512, NUM_CH=2).
module tb_wrapper_data_req_mc;

`ifdef WRAPPER_DATA_REQ_SEQ_CHECK_EN
  localparam bit SEQ_ON = 1'b1;
`else
  localparam bit SEQ_ON = 1'b0;
`endif

  localparam logic [1:0] TI = 2'b00;
  localparam logic [1:0] TB = 2'b01;
  localparam logic [1:0] TW = 2'b10;

  logic        hclk;
  logic        hresetn;
  logic        hsels;
  logic [10:0] haddrs;
  logic [1:0]  htranss;
  logic        hwrites;
  logic        hreadys;
  logic [1:0]  constructor_ready;
  logic [1:0]  data_req;
  logic [1:0]  packet_done;
  logic [1:0]  seq_err;

  wrapper_data_req_mc #(.ADDRWIDTH(11), .PACKETWIDTH(512), .NUM_CH(2)) dut (
    .hclk              (hclk),
    .hresetn           (hresetn),
    .hsels             (hsels),
    .haddrs            (haddrs),
    .htranss           (htranss),
    .hwrites           (hwrites),
    .hreadys           (hreadys),
    .constructor_ready (constructor_ready),
    .data_req          (data_req),
    .packet_done       (packet_done),
    .seq_err           (seq_err)
  );

  initial hclk = 1'b1;
  always #5 hclk = ~hclk;

  typedef struct {
    logic [1:0] req;
    logic [1:0] done;
    logic [1:0] seq;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input string what,
                       input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %b expected %b", name, what, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle on the falling edge.
  initial begin
    forever begin
      @(negedge hclk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check(e.name, "data_req",    data_req,    e.req);
        check(e.name, "packet_done", packet_done, e.done);
        check(e.name, "seq_err",     seq_err,     e.seq);
      end
    end
  end

  task automatic cyc(input logic rst, input logic [1:0] rdy, input logic [1:0] tr,
                     input logic [10:0] addr, input logic hrdy,
                     input logic [1:0] e_req, input logic [1:0] e_done,
                     input logic [1:0] e_seq, input string name);
    exp_t e;
    hresetn           = rst;
    constructor_ready = rdy;
    htranss           = tr;
    haddrs            = addr;
    hreadys           = hrdy;
    hsels             = 1'b1;
    hwrites           = 1'b1;
    e.req  = e_req;
    e.done = e_done;
    e.seq  = SEQ_ON ? e_seq : 2'b00;
    e.name = name;
    q.push_back(e);
    @(posedge hclk);
    #1;
  endtask

  initial begin
    hresetn = 1'b0; constructor_ready = 2'b00; htranss = TI; haddrs = '0;
    hreadys = 1'b1; hsels = 1'b0; hwrites = 1'b0;
    @(posedge hclk);
    #1;

    // Reset behaviour and rising pass-through
    cyc(0, 2'b00, TI, 11'h000, 1, 2'b00, 2'b00, 2'b00, "rst_idle");
    cyc(0, 2'b01, TI, 11'h000, 1, 2'b01, 2'b00, 2'b00, "rst_passthru");
    cyc(1, 2'b00, TI, 11'h000, 1, 2'b00, 2'b00, 2'b00, "idle");
    cyc(1, 2'b01, TI, 11'h000, 1, 2'b01, 2'b00, 2'b00, "rise");

    // Full ch0 packet with a stalled last data phase
    for (int i = 0; i < 15; i++)
      cyc(1, 2'b01, TW, 11'(i * 4), 1, 2'b01, 2'b00, 2'b00, "ch0_word");
    cyc(1, 2'b01, TW, 11'h03C, 1, 2'b00, 2'b00, 2'b00, "ch0_last_addr");
    cyc(1, 2'b01, TI, 11'h000, 0, 2'b00, 2'b00, 2'b00, "ch0_wait1");
    cyc(1, 2'b01, TI, 11'h000, 0, 2'b00, 2'b00, 2'b00, "ch0_wait2");
    cyc(1, 2'b01, TI, 11'h000, 1, 2'b00, 2'b01, 2'b00, "ch0_done");
    cyc(1, 2'b01, TI, 11'h000, 1, 2'b01, 2'b00, 2'b00, "ch0_rerise");

    // Collision of ch0 last address with ch1 last data
    cyc(1, 2'b11, TI, 11'h000, 1, 2'b11, 2'b00, 2'b00, "ch1_rise");
    cyc(1, 2'b11, TW, 11'h07C, 1, 2'b01, 2'b00, 2'b00, "ch1_last_addr");
    cyc(1, 2'b11, TW, 11'h03C, 1, 2'b00, 2'b10, 2'b10, "collision");
    cyc(1, 2'b11, TI, 11'h000, 1, 2'b10, 2'b01, 2'b01, "ch0_done_ch1_rise");
    cyc(1, 2'b11, TI, 11'h000, 1, 2'b11, 2'b00, 2'b00, "both_active");

    // last_hit wins over a simultaneous ready fall
    cyc(1, 2'b10, TW, 11'h03C, 1, 2'b10, 2'b00, 2'b00, "prio_fall_last");
    cyc(1, 2'b10, TI, 11'h000, 1, 2'b10, 2'b01, 2'b01, "prio_done");

    // Out-of-order word on ch1
    cyc(1, 2'b10, TW, 11'h040, 1, 2'b10, 2'b00, 2'b00, "seq_w0");
    cyc(1, 2'b10, TW, 11'h048, 1, 2'b10, 2'b00, 2'b00, "seq_w2");
    cyc(1, 2'b10, TI, 11'h000, 1, 2'b10, 2'b00, 2'b10, "seq_pulse");
    cyc(1, 2'b10, TI, 11'h000, 1, 2'b10, 2'b00, 2'b00, "seq_clear");

    // BUSY transfer and IDLE last_hit are not acted on
    cyc(1, 2'b10, TB, 11'h07C, 1, 2'b10, 2'b00, 2'b00, "busy_ignored");
    cyc(1, 2'b10, TW, 11'h03C, 1, 2'b10, 2'b00, 2'b00, "idle_lasthit_lo");
    cyc(1, 2'b11, TW, 11'h03C, 1, 2'b11, 2'b00, 2'b00, "idle_lasthit_hi");
    cyc(1, 2'b11, TI, 11'h000, 1, 2'b11, 2'b00, 2'b00, "idle_lasthit_ignored");

    // Reset while ch0 sits in LAST_DATA
    cyc(1, 2'b11, TW, 11'h03C, 1, 2'b10, 2'b00, 2'b00, "rst_pkt_last");
    cyc(0, 2'b11, TI, 11'h000, 1, 2'b11, 2'b00, 2'b01, "rst_mid_pkt");
    cyc(1, 2'b00, TI, 11'h000, 1, 2'b00, 2'b00, 2'b00, "post_rst_idle");
    cyc(1, 2'b11, TI, 11'h000, 1, 2'b11, 2'b00, 2'b00, "post_rst_rise");
    cyc(1, 2'b11, TW, 11'h040, 1, 2'b11, 2'b00, 2'b00, "post_rst_w_ch1");
    cyc(1, 2'b11, TW, 11'h000, 1, 2'b11, 2'b00, 2'b00, "post_rst_w_ch0");
    cyc(1, 2'b00, TI, 11'h000, 1, 2'b00, 2'b00, 2'b00, "end");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge hclk);
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
